// File: rtl/bullet_scheduler.sv
// bullet_scheduler: shared bullet-pool controller for the two-player tank game.
//
// Both players' shoot buttons arbitrate round-robin for NUM_SLOTS bullet slots.
// A serviced request either takes the lowest free slot (grant) or is refused
// (drop) when the player is at quota or the pool is full. Live slots advance
// BULLET_SPEED pixels per tick in their stored direction and retire on
// collision or when the next move would leave the screen.
//
// Ports:
//   clk_i, reset_i             clock, synchronous active-low reset
//   tick_i                     slow update clock (level, rising edge used)
//   player_{1,2}_shoot_i       shoot buttons (level, rising edge used)
//   player_{1,2}_{x,y}_i       spawn positions (10 bits)
//   player_{1,2}_dir_i         facing: 00 up, 01 down, 10 left, 11 right
//   collide_i[k]               slot k hit something this cycle
//   slot_valid_o/slot_owner_o  per-slot live flag / owner (0 = P1, 1 = P2)
//   slot_x_o/slot_y_o          packed positions, slot k at [10k+9:10k]
//   grant_o/drop_o             one-cycle pulses, bit 0 = P1, bit 1 = P2

// Per-slot state: position, direction, owner and the move/retire rules.
module bullet_slot #(
    parameter int BULLET_SPEED = 2,
    parameter int H_MAX        = 640,
    parameter int V_MAX        = 480
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       i_move,
    input  logic       i_collide,
    input  logic       i_alloc,
    input  logic       i_owner,
    input  logic [9:0] i_x,
    input  logic [9:0] i_y,
    input  logic [1:0] i_dir,
    output logic       o_valid,
    output logic       o_owner,
    output logic [9:0] o_x,
    output logic [9:0] o_y
);
    localparam logic [10:0] L_SPD11 = 11'(BULLET_SPEED);
    localparam logic [9:0]  L_SPD10 = 10'(BULLET_SPEED);
    localparam logic [10:0] L_HLIM  = 11'(H_MAX - 1);
    localparam logic [10:0] L_VLIM  = 11'(V_MAX - 1);

    logic       r_valid;
    logic       r_owner;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic [1:0] r_dir;

    logic [10:0] w_x11, w_y11, w_inc_x, w_inc_y;
    logic [9:0]  w_dec_x, w_dec_y;
    logic [9:0]  w_nx, w_ny;
    logic        w_exit;

    // 11-bit sums so x+speed cannot wrap before the edge compare.
    assign w_x11   = {1'b0, r_x};
    assign w_y11   = {1'b0, r_y};
    assign w_inc_x = w_x11 + L_SPD11;
    assign w_inc_y = w_y11 + L_SPD11;
    // Decrements are only used once the underflow compare has ruled out wrap.
    assign w_dec_x = r_x - L_SPD10;
    assign w_dec_y = r_y - L_SPD10;

    always_comb begin
        w_exit = 1'b0;
        w_nx   = r_x;
        w_ny   = r_y;
        case (r_dir)
            2'b00: if (w_y11 < L_SPD11) w_exit = 1'b1; else w_ny = w_dec_y;
            2'b01: if (w_inc_y > L_VLIM) w_exit = 1'b1; else w_ny = w_inc_y[9:0];
            2'b10: if (w_x11 < L_SPD11) w_exit = 1'b1; else w_nx = w_dec_x;
            default: if (w_inc_x > L_HLIM) w_exit = 1'b1; else w_nx = w_inc_x[9:0];
        endcase
    end

    // Allocation only targets free slots, so it never competes with the
    // collide/move path; collision beats movement; freed slots keep x/y.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_valid <= 1'b0;
            r_owner <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_dir   <= '0;
        end else if (i_alloc) begin
            r_valid <= 1'b1;
            r_owner <= i_owner;
            r_x     <= i_x;
            r_y     <= i_y;
            r_dir   <= i_dir;
        end else if (r_valid) begin
            if (i_collide) begin
                r_valid <= 1'b0;
            end else if (i_move) begin
                if (w_exit) begin
                    r_valid <= 1'b0;
                end else begin
                    r_x <= w_nx;
                    r_y <= w_ny;
                end
            end
        end
    end

    assign o_valid = r_valid;
    assign o_owner = r_owner;
    assign o_x     = r_x;
    assign o_y     = r_y;
endmodule

module bullet_scheduler #(
    parameter int NUM_SLOTS    = 4,
    parameter int PLAYER_QUOTA = 2,
    parameter int BULLET_SPEED = 2,
    parameter int H_MAX        = 640,
    parameter int V_MAX        = 480
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    tick_i,
    input  logic                    player_1_shoot_i,
    input  logic                    player_2_shoot_i,
    input  logic [9:0]              player_1_x_i,
    input  logic [9:0]              player_1_y_i,
    input  logic [9:0]              player_2_x_i,
    input  logic [9:0]              player_2_y_i,
    input  logic [1:0]              player_1_dir_i,
    input  logic [1:0]              player_2_dir_i,
    input  logic [NUM_SLOTS-1:0]    collide_i,
    output logic [NUM_SLOTS-1:0]    slot_valid_o,
    output logic [NUM_SLOTS-1:0]    slot_owner_o,
    output logic [NUM_SLOTS*10-1:0] slot_x_o,
    output logic [NUM_SLOTS*10-1:0] slot_y_o,
    output logic [1:0]              grant_o,
    output logic [1:0]              drop_o
);
    localparam logic [3:0] L_QUOTA = 4'(PLAYER_QUOTA);

    logic [1:0] r_shoot_prev;
    logic       r_tick_prev;
    logic       r_tick_pulse;
    logic [1:0] r_pend;
    logic       r_rr;
    logic [1:0] r_grant;
    logic [1:0] r_drop;

    logic [1:0]                     w_shoot, w_rise, w_clr;
    logic                           w_svc, w_sel, w_ok, w_free_any;
    logic [3:0]                     w_cnt;
    logic [NUM_SLOTS-1:0]           w_free_oh, w_alloc;
    logic [NUM_SLOTS-1:0]           w_valid, w_owner;
    logic [NUM_SLOTS-1:0][9:0]      w_x, w_y;
    logic [9:0]                     w_sx, w_sy;
    logic [1:0]                     w_sdir;

    assign w_shoot = {player_2_shoot_i, player_1_shoot_i};
    assign w_rise  = w_shoot & ~r_shoot_prev;

    // Round-robin only matters when both are pending; otherwise serve the one.
    assign w_svc = |r_pend;
    assign w_sel = (r_pend == 2'b11) ? r_rr : r_pend[1];
    assign w_clr = w_svc ? (w_sel ? 2'b10 : 2'b01) : 2'b00;

    // Quota and free-slot search see registered state only, so slots freed
    // this cycle still count and are not reused until next cycle.
    always_comb begin
        w_cnt = '0;
        for (int k = 0; k < NUM_SLOTS; k++)
            if (w_valid[k] && (w_owner[k] == w_sel)) w_cnt = w_cnt + 4'd1;
    end

    always_comb begin
        w_free_oh  = '0;
        w_free_any = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (!w_valid[k] && !w_free_any) begin
                w_free_oh[k] = 1'b1;
                w_free_any   = 1'b1;
            end
        end
    end

    assign w_ok    = w_svc && w_free_any && (w_cnt < L_QUOTA);
    assign w_alloc = w_ok ? w_free_oh : '0;

    assign w_sx   = w_sel ? player_2_x_i   : player_1_x_i;
    assign w_sy   = w_sel ? player_2_y_i   : player_1_y_i;
    assign w_sdir = w_sel ? player_2_dir_i : player_1_dir_i;

    // Previous samples reset high so inputs held through reset do not fire.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_shoot_prev <= 2'b11;
            r_tick_prev  <= 1'b1;
            r_tick_pulse <= 1'b0;
            r_pend       <= '0;
            r_rr         <= 1'b0;
            r_grant      <= '0;
            r_drop       <= '0;
        end else begin
            r_shoot_prev <= w_shoot;
            r_tick_prev  <= tick_i;
            r_tick_pulse <= tick_i & ~r_tick_prev;
            r_pend       <= (r_pend & ~w_clr) | w_rise;
            if (w_svc) r_rr <= ~w_sel;
            r_grant      <= (w_svc &&  w_ok) ? w_clr : 2'b00;
            r_drop       <= (w_svc && !w_ok) ? w_clr : 2'b00;
        end
    end

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
        bullet_slot #(
            .BULLET_SPEED (BULLET_SPEED),
            .H_MAX        (H_MAX),
            .V_MAX        (V_MAX)
        ) u_slot (
            .clk_i     (clk_i),
            .reset_i   (reset_i),
            .i_move    (r_tick_pulse),
            .i_collide (collide_i[k]),
            .i_alloc   (w_alloc[k]),
            .i_owner   (w_sel),
            .i_x       (w_sx),
            .i_y       (w_sy),
            .i_dir     (w_sdir),
            .o_valid   (w_valid[k]),
            .o_owner   (w_owner[k]),
            .o_x       (w_x[k]),
            .o_y       (w_y[k])
        );
    end

    assign slot_valid_o = w_valid;
    assign slot_owner_o = w_owner;
    assign slot_x_o     = w_x;
    assign slot_y_o     = w_y;
    assign grant_o      = r_grant;
    assign drop_o       = r_drop;
endmodule

// File: tb/tb_bullet_scheduler.sv
// Scoreboard bench for bullet_scheduler: each press pushes the expected
// grant/drop event; a negedge monitor pops and compares when the DUT pulses.
module tb_bullet_scheduler;
    localparam int N = 4;

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic           tick_i;
    logic           p1_shoot, p2_shoot;
    logic [9:0]     p1_x, p1_y, p2_x, p2_y;
    logic [1:0]     p1_dir, p2_dir;
    logic [N-1:0]   collide_i;
    logic [N-1:0]   slot_valid_o, slot_owner_o;
    logic [N*10-1:0] slot_x_o, slot_y_o;
    logic [1:0]     grant_o, drop_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0] grant;
        logic [1:0] drop;
        int         slot;
        logic       owner;
        logic [9:0] x;
        logic [9:0] y;
    } exp_t;

    exp_t sb[$];

    always #5 clk_i = ~clk_i;

    bullet_scheduler #(
        .NUM_SLOTS(N), .PLAYER_QUOTA(2), .BULLET_SPEED(2), .H_MAX(640), .V_MAX(480)
    ) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .tick_i           (tick_i),
        .player_1_shoot_i (p1_shoot),
        .player_2_shoot_i (p2_shoot),
        .player_1_x_i     (p1_x),
        .player_1_y_i     (p1_y),
        .player_2_x_i     (p2_x),
        .player_2_y_i     (p2_y),
        .player_1_dir_i   (p1_dir),
        .player_2_dir_i   (p2_dir),
        .collide_i        (collide_i),
        .slot_valid_o     (slot_valid_o),
        .slot_owner_o     (slot_owner_o),
        .slot_x_o         (slot_x_o),
        .slot_y_o         (slot_y_o),
        .grant_o          (grant_o),
        .drop_o           (drop_o)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [9:0] sx(input int k);
        return slot_x_o[10*k +: 10];
    endfunction

    function automatic logic [9:0] sy(input int k);
        return slot_y_o[10*k +: 10];
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic push_g(input int p, input int slot, input logic [9:0] x, input logic [9:0] y);
        exp_t e;
        e.grant = (p == 0) ? 2'b01 : 2'b10;
        e.drop  = 2'b00;
        e.slot  = slot;
        e.owner = (p == 1);
        e.x     = x;
        e.y     = y;
        sb.push_back(e);
    endtask

    task automatic push_d(input int p);
        exp_t e;
        e.grant = 2'b00;
        e.drop  = (p == 0) ? 2'b01 : 2'b10;
        e.slot  = 0;
        e.owner = 1'b0;
        e.x     = '0;
        e.y     = '0;
        sb.push_back(e);
    endtask

    // Rise at E0, release after it; grant/drop is visible after E1.
    task automatic press(input int p);
        if (p == 0) p1_shoot = 1'b1; else p2_shoot = 1'b1;
        cyc(1);
        p1_shoot = 1'b0;
        p2_shoot = 1'b0;
        cyc(1);
    endtask

    task automatic tick();
        tick_i = 1'b1;
        cyc(1);
        tick_i = 1'b0;
        cyc(1);
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        cyc(2);
        reset_i = 1'b1;
        cyc(1);
    endtask

    task automatic sb_drain(input string tag);
        @(negedge clk_i);
        #1;
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk_i) begin
        if (reset_i === 1'b1 && (grant_o != 2'b00 || drop_o != 2'b00)) begin
            if (sb.size() == 0) begin
                chk("unexpected_evt", {60'd0, grant_o, drop_o}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_grant", 64'(grant_o), 64'(e.grant));
                chk("sb_drop",  64'(drop_o),  64'(e.drop));
                if (e.grant != 2'b00) begin
                    chk("sb_valid", 64'(slot_valid_o[e.slot]), 64'd1);
                    chk("sb_owner", 64'(slot_owner_o[e.slot]), 64'(e.owner));
                    chk("sb_x",     64'(sx(e.slot)),           64'(e.x));
                    chk("sb_y",     64'(sy(e.slot)),           64'(e.y));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        reset_i   = 1'b0;
        tick_i    = 1'b0;
        p1_shoot  = 1'b1;
        p2_shoot  = 1'b0;
        collide_i = '0;
        p1_x = 10'd100; p1_y = 10'd200; p1_dir = 2'b11;
        p2_x = 10'd300; p2_y = 10'd50;  p2_dir = 2'b00;

        // Reset with P1 shoot held high.
        cyc(3);
        chk("rst_valid", 64'(slot_valid_o), 64'd0);
        chk("rst_owner", 64'(slot_owner_o), 64'd0);
        chk("rst_x",     64'(slot_x_o),     64'd0);
        chk("rst_y",     64'(slot_y_o),     64'd0);
        chk("rst_grant", 64'(grant_o),      64'd0);
        chk("rst_drop",  64'(drop_o),       64'd0);
        reset_i = 1'b1;
        cyc(5);
        chk("held_valid", 64'(slot_valid_o), 64'd0);
        chk("held_grant", 64'(grant_o),      64'd0);
        p1_shoot = 1'b0;
        cyc(1);
        sb_drain("held_sb");

        // Single shot and movement, then collision in the move cycle.
        push_g(0, 0, 10'd100, 10'd200);
        press(0);
        sb_drain("single_sb");
        tick(); tick(); tick();
        chk("move_x", 64'(sx(0)), 64'd106);
        chk("move_y", 64'(sy(0)), 64'd200);
        tick_i = 1'b1;
        cyc(1);
        tick_i = 1'b0;
        collide_i = 4'b0001;
        cyc(1);
        collide_i = '0;
        chk("colmove_valid", 64'(slot_valid_o[0]), 64'd0);
        chk("colmove_x",     64'(sx(0)),           64'd106);

        // Reset mid-operation, then simultaneous shoot with rr = 0.
        push_g(0, 0, 10'd100, 10'd200);
        press(0);
        sb_drain("pre_rst_sb");
        do_reset();
        chk("midrst_valid", 64'(slot_valid_o), 64'd0);
        push_g(0, 0, 10'd100, 10'd200);
        push_g(1, 1, 10'd300, 10'd50);
        p1_shoot = 1'b1;
        p2_shoot = 1'b1;
        cyc(1);
        p1_shoot = 1'b0;
        p2_shoot = 1'b0;
        cyc(1);
        chk("simul_e1", 64'(grant_o), 64'b01);
        cyc(1);
        chk("simul_e2", 64'(grant_o), 64'b10);
        sb_drain("simul_sb");

        // Quota and pool full.
        do_reset();
        push_g(0, 0, 10'd100, 10'd200); press(0);
        push_g(0, 1, 10'd100, 10'd200); press(0);
        push_d(0);                      press(0);
        push_g(1, 2, 10'd300, 10'd50);  press(1);
        push_g(1, 3, 10'd300, 10'd50);  press(1);
        push_d(1);                      press(1);
        sb_drain("quota_sb");
        chk("quota_valid", 64'(slot_valid_o), 64'hF);
        chk("quota_owner", 64'(slot_owner_o), 64'hC);

        // Screen edges.
        do_reset();
        p2_x = 10'd637; p2_y = 10'd10; p2_dir = 2'b11;
        push_g(1, 0, 10'd637, 10'd10);
        press(1);
        tick();
        chk("edge639_valid", 64'(slot_valid_o[0]), 64'd1);
        chk("edge639_x",     64'(sx(0)),           64'd639);
        tick();
        chk("edge641_valid", 64'(slot_valid_o[0]), 64'd0);
        chk("edge641_x",     64'(sx(0)),           64'd639);
        p2_x = 10'd638;
        push_g(1, 0, 10'd638, 10'd10);
        press(1);
        tick();
        chk("right_valid", 64'(slot_valid_o[0]), 64'd0);
        chk("right_x",     64'(sx(0)),           64'd638);
        p2_x = 10'd50; p2_y = 10'd1; p2_dir = 2'b00;
        push_g(1, 0, 10'd50, 10'd1);
        press(1);
        tick();
        chk("up_valid", 64'(slot_valid_o[0]), 64'd0);
        chk("up_y",     64'(sy(0)),           64'd1);
        sb_drain("edge_sb");

        // Collision and tick edge in the P1 service cycle.
        do_reset();
        push_g(0, 0, 10'd100, 10'd200);
        press(0);
        push_g(0, 1, 10'd100, 10'd200);
        p1_shoot = 1'b1;
        cyc(1);
        p1_shoot  = 1'b0;
        tick_i    = 1'b1;
        collide_i = 4'b0001;
        cyc(1);
        tick_i    = 1'b0;
        collide_i = '0;
        chk("ct_slot0", 64'(slot_valid_o[0]), 64'd0);
        chk("ct_slot1", 64'(slot_valid_o[1]), 64'd1);
        cyc(1);
        chk("ct_slot0_x", 64'(sx(0)), 64'd100);
        chk("ct_valid",   64'(slot_valid_o), 64'b0010);
        sb_drain("ct_sb");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bullet_scheduler.md
# bullet_scheduler

Shared bullet-pool controller for the two-player tank game. Both players' shoot buttons arbitrate round-robin for a fixed pool of bullet slots. Each slot's position advances on the game's slow update tick, and a slot is retired on collision or at the screen edge. The block sits beside `player_rgb`, driven by the same `clk_i` and slow update clock. Its slot outputs feed the bullet renderer and the collision logic, and that logic returns per-slot hit flags.

## Interface
Parameters:
- `NUM_SLOTS`, 4: bullet slots in the pool; legal range 2..8.
- `PLAYER_QUOTA`, 2: maximum live slots owned by one player.
- `BULLET_SPEED`, 2: pixels moved per tick.
- `H_MAX`, 640: visible width in pixels.
- `V_MAX`, 480: visible height in pixels.

Ports:
- `clk_i` in 1: the single clock.
- `reset_i` in 1: synchronous, active-low reset.
- `tick_i` in 1: slow update clock (level); its rising edge is detected internally.
- `player_1_shoot_i`, `player_2_shoot_i` in 1 each: shoot buttons (level).
- `player_1_x_i`, `player_1_y_i`, `player_2_x_i`, `player_2_y_i` in 10 each: player spawn points.
- `player_1_dir_i`, `player_2_dir_i` in 2 each: facing; 00 up, 01 down, 10 left, 11 right.
- `collide_i` in `NUM_SLOTS`: bit k set means slot k hit a wall, block or tank.
- `slot_valid_o` out `NUM_SLOTS`: slot k is live.
- `slot_owner_o` out `NUM_SLOTS`: owner of slot k; 0 = player 1, 1 = player 2.
- `slot_x_o`, `slot_y_o` out `NUM_SLOTS*10` each: packed positions; slot k occupies bits [10k+9:10k].
- `grant_o` out 2: one-cycle pulse; bit 0 = player 1, bit 1 = player 2.
- `drop_o` out 2: one-cycle pulse when a request is refused.

## Operation
- **Edge detection:** the previous-sample registers for both shoot inputs and for `tick_i` reset to 1. An input already held high through reset therefore does not fire.
- **Request capture:** a shoot rising edge sets `pend[p]`. A rising edge while `pend[p]` is already set is merged (no second request).
- **Arbitration:**
  - At most one request is serviced per cycle.
  - A round-robin pointer `rr` (reset = 0) gives priority to player `rr`.
  - After any grant or drop, `rr` points to the other player.
  - The serviced request's `pend` bit clears.
- **Allocation:**
  - Owner count = popcount of (`slot_valid` & owner==p), computed from the current registered state.
  - If the count ≥ `PLAYER_QUOTA`, or no slot is free: pulse `drop_o[p]` and leave all slots unchanged.
  - Otherwise take the lowest-index free slot:
    - valid = 1, owner = p;
    - x, y = that player's x, y sampled in the service cycle;
    - the slot also stores that player's dir (2-bit internal register);
    - pulse `grant_o[p]`.
- **Retirement:** `collide_i[k]` high while slot k is valid clears slot k next edge. Collision takes priority over movement.
- **Movement:** on a tick rising edge, every valid, non-colliding slot moves `BULLET_SPEED` pixels in its stored direction. The slot is freed instead of moved when the move would leave the screen:
  - up: y < `BULLET_SPEED`;
  - down: y + `BULLET_SPEED` > `V_MAX`-1;
  - left: x < `BULLET_SPEED`;
  - right: x + `BULLET_SPEED` > `H_MAX`-1.
- **Arithmetic width:** boundary comparisons use 11-bit arithmetic; no wrap-around is possible.
- **Same-cycle events:**
  - A slot freed by collision or edge in a cycle is not allocatable until the following cycle.
  - A slot allocated in a tick cycle does not move in that cycle.
- **Freed-slot values:** freed slots keep their last x/y; consumers must qualify them with `slot_valid_o`.

## Timing
- **Reset values** (`reset_i`=0 at a clock edge):
  - `slot_valid_o` = 0, `slot_owner_o` = 0;
  - `slot_x_o` = `slot_y_o` = 0;
  - `grant_o` = `drop_o` = 0;
  - `pend` = 0, `rr` = 0.
- **Reset mid-operation:** discards pending requests and live bullets.
- **Shoot latency:** the shoot input is sampled high at edge E0 with previous sample low, so `pend` is set at E0. At E1 the slot and `grant_o`/`drop_o` update. Shoot-to-grant latency is 2 edges.
- **Simultaneous shoots:** both players' edges at E0 give the `rr` player its grant at E1 and the other at E2.
- **Tick latency:** tick rising edge sampled at T0 produces the position update at T1.
- **Collision latency:** `collide_i` sampled at C0 clears `slot_valid_o` at C0 (visible next cycle).
- **Output pulses:** `grant_o` and `drop_o` are exactly one cycle wide.

## Test plan
- **Reset with shoot held:** hold `reset_i`=0 for 3 cycles with `player_1_shoot_i`=1, then release. Required: all outputs 0 and no grant while shoot stays high.
- **Single shot and movement:**
  - P1 at (100,200) facing right presses once. Required: `grant_o`=01 two edges later; slot 0 valid, owner 0, at (100,200).
  - Issue 3 ticks. Required: slot 0 at (106,200).
- **Simultaneous shoot:** both players rise in the same cycle with `rr`=0. Required: P1 gets slot 0 at E1 and P2 gets slot 1 at E2, with `grant_o` 01 then 10.
- **Quota and pool full** (`NUM_SLOTS`=4, quota 2):
  - P1 fires 3 times. Required: the third shot gives `drop_o`=01.
  - P2 then fires 3 times. Required: slots 2 and 3 are granted and the third shot is dropped.
- **Edge exit:** P2 at (638,10) facing right, then one tick. Required: slot freed and not moved.
  - Same test facing up at y=1. Required: slot freed.
- **Collision vs tick:** assert `collide_i[0]` in the same cycle as a tick rising edge while P1 requests. Required: slot 0 freed, not moved. The new grant takes slot 1 (the lowest-index free slot), not slot 0.
